// File: rtl/serv_bus_pkg.sv
// Shared types and constants for the SERV ibus/dbus Wishbone arbiter.
package serv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2
  } state_e;

  localparam logic [1:0]  GNT_I      = 2'b01;
  localparam logic [1:0]  GNT_D      = 2'b10;
  localparam logic [31:0] TO_RDT_DEF = 32'h0000_0000;

endpackage

// File: rtl/serv_bus_wdt.sv
// Bus watchdog: counts granted cycles without an ack and flags the last allowed one.
module serv_bus_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_ack,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside a transfer, so every grant starts counting from 0.
  always_comb begin
    cnt_d = '0;
    if (i_run && !i_ack) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_expire = i_run && !i_ack && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/serv_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone master between SERV ibus and dbus,
// one outstanding transfer, with a watchdog that forces completion on a lost ack.
module serv_bus_arbiter
  import serv_bus_pkg::*;
#(
  parameter int             AW      = 32,
  parameter int             DW      = 32,
  parameter int             TIMEOUT = 255,
  parameter logic [DW-1:0]  TO_RDT  = DW'(TO_RDT_DEF)
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic [AW-1:0]   i_ibus_adr,
  input  logic            i_ibus_cyc,
  output logic [DW-1:0]   o_ibus_rdt,
  output logic            o_ibus_ack,
  input  logic [AW-1:0]   i_dbus_adr,
  input  logic [DW-1:0]   i_dbus_dat,
  input  logic [DW/8-1:0] i_dbus_sel,
  input  logic            i_dbus_we,
  input  logic            i_dbus_cyc,
  output logic [DW-1:0]   o_dbus_rdt,
  output logic            o_dbus_ack,
  output logic [AW-1:0]   o_wb_adr,
  output logic [DW-1:0]   o_wb_dat,
  output logic [DW/8-1:0] o_wb_sel,
  output logic            o_wb_we,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  input  logic [DW-1:0]   i_wb_rdt,
  input  logic            i_wb_ack,
  output logic [1:0]      o_gnt,
  output logic            o_timeout,
  input  logic            i_timeout_clr
);

  state_e     state_q, state_d;
  logic [1:0] last_gnt_q, last_gnt_d;
  logic [1:0] mask_q, mask_d;
  logic       timeout_q, timeout_d;

  logic       busy, expire, gnt_cyc, req_i, req_d, done, to_set;
  logic [1:0] gnt;
  logic [DW-1:0] ack_rdt;

  assign busy    = (state_q != IDLE);
  assign gnt     = (state_q == BUS_I) ? GNT_I : (state_q == BUS_D) ? GNT_D : 2'b00;
  assign gnt_cyc = (state_q == BUS_I) ? i_ibus_cyc : i_dbus_cyc;
  // SERV holds cyc for one cycle after its ack; the mask hides that echo.
  assign req_i   = i_ibus_cyc && !mask_q[0];
  assign req_d   = i_dbus_cyc && !mask_q[1];

  generate
    if (TIMEOUT > 0) begin : g_wdt
      serv_bus_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_run    (busy),
        .i_ack    (i_wb_ack),
        .o_expire (expire)
      );
    end else begin : g_no_wdt
      assign expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    mask_d     = '0;
    timeout_d  = timeout_q;
    done       = 1'b0;
    to_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i && (!req_d || last_gnt_q == GNT_D)) begin
          state_d    = BUS_I;
          last_gnt_d = GNT_I;
        end else if (req_d) begin
          state_d    = BUS_D;
          last_gnt_d = GNT_D;
        end
      end
      BUS_I, BUS_D: begin
        // Real ack beats abort, abort beats a forced (watchdog) ack.
        if (i_wb_ack) begin
          done = 1'b1;
        end else if (!gnt_cyc) begin
          state_d = IDLE;
        end else if (expire) begin
          done   = 1'b1;
          to_set = 1'b1;
        end
        if (done) begin
          state_d = IDLE;
          mask_d  = gnt;
        end
      end
      default: state_d = IDLE;
    endcase
    if (to_set)             timeout_d = 1'b1;
    else if (i_timeout_clr) timeout_d = 1'b0;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= GNT_D;
      mask_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      mask_q     <= mask_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ack_rdt    = i_wb_ack ? i_wb_rdt : TO_RDT;
  assign o_ibus_ack = done && gnt[0];
  assign o_dbus_ack = done && gnt[1];
  assign o_ibus_rdt = o_ibus_ack ? ack_rdt : '0;
  assign o_dbus_rdt = o_dbus_ack ? ack_rdt : '0;
  assign o_wb_cyc   = busy;
  assign o_wb_stb   = busy;
  assign o_gnt      = gnt;
  assign o_timeout  = timeout_q;

  always_comb begin
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_we  = 1'b0;
    case (state_q)
      BUS_I: begin
        o_wb_adr = i_ibus_adr;
        o_wb_sel = '1;
      end
      BUS_D: begin
        o_wb_adr = i_dbus_adr;
        o_wb_dat = i_dbus_dat;
        o_wb_sel = i_dbus_sel;
        o_wb_we  = i_dbus_we;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_serv_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [AW-1:0] i_ibus_adr;
  logic          i_ibus_cyc;
  logic [DW-1:0] o_ibus_rdt;
  logic          o_ibus_ack;
  logic [AW-1:0] i_dbus_adr;
  logic [DW-1:0] i_dbus_dat;
  logic [3:0]    i_dbus_sel;
  logic          i_dbus_we;
  logic          i_dbus_cyc;
  logic [DW-1:0] o_dbus_rdt;
  logic          o_dbus_ack;
  logic [AW-1:0] o_wb_adr;
  logic [DW-1:0] o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we, o_wb_cyc, o_wb_stb;
  logic [DW-1:0] i_wb_rdt;
  logic          i_wb_ack;
  logic [1:0]    o_gnt;
  logic          o_timeout;
  logic          i_timeout_clr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serv_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .TO_RDT(32'h0)) dut (
    .clk(clk), .i_rst(i_rst),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc), .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel), .i_dbus_we(i_dbus_we),
    .i_dbus_cyc(i_dbus_cyc), .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack),
    .o_gnt(o_gnt), .o_timeout(o_timeout), .i_timeout_clr(i_timeout_clr)
  );

  task automatic drive_pt(); @(posedge clk); #1; endtask
  task automatic sample();   @(negedge clk);     endtask

  task automatic idle_inputs();
    i_ibus_adr = '0; i_ibus_cyc = 0; i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0;
    i_dbus_we = 0; i_dbus_cyc = 0; i_wb_rdt = '0; i_wb_ack = 0; i_timeout_clr = 0;
  endtask

  task automatic pulse_reset();
    drive_pt(); idle_inputs(); i_rst = 1;
    drive_pt(); i_rst = 0;
  endtask

  task automatic test_reset();
    i_rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    sample();
    vectors++;
    if ({o_wb_cyc, o_wb_stb, o_gnt, o_timeout, o_ibus_ack, o_dbus_ack} !== 7'b0) begin
      miscompares++; $display("FAIL reset_state: got %b want 0000000", {o_wb_cyc, o_wb_stb, o_gnt, o_timeout, o_ibus_ack, o_dbus_ack});
    end
    drive_pt(); i_rst = 0;
    sample();
    vectors++;
    if ({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we} !== '0) begin
      miscompares++; $display("FAIL reset_fields: got %h want 0", {o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we});
    end
  endtask

  task automatic test_ibus_fetch();
    drive_pt(); i_ibus_adr = 32'h100; i_ibus_cyc = 1;
    sample();
    vectors++;
    if (o_wb_cyc !== 1'b0) begin miscompares++; $display("FAIL ifetch_req_cycle: cyc got %b want 0", o_wb_cyc); end
    drive_pt(); sample();
    vectors++;
    if ({o_wb_cyc, o_wb_stb, o_gnt, o_wb_adr, o_wb_we, o_wb_sel, o_wb_dat} !== {1'b1, 1'b1, 2'b01, 32'h100, 1'b0, 4'hf, 32'h0}) begin
      miscompares++; $display("FAIL ifetch_fields: got %b %b %b %h %b %h %h", o_wb_cyc, o_wb_stb, o_gnt, o_wb_adr, o_wb_we, o_wb_sel, o_wb_dat);
    end
    vectors++;
    if (o_ibus_ack !== 1'b0) begin miscompares++; $display("FAIL ifetch_early_ack: got %b want 0", o_ibus_ack); end
    drive_pt(); i_wb_ack = 1; i_wb_rdt = 32'h13;
    sample();
    vectors++;
    if ({o_ibus_ack, o_ibus_rdt, o_dbus_ack} !== {1'b1, 32'h13, 1'b0}) begin
      miscompares++; $display("FAIL ifetch_ack: got ack %b rdt %h dack %b want 1 00000013 0", o_ibus_ack, o_ibus_rdt, o_dbus_ack);
    end
    drive_pt(); i_wb_ack = 0; i_ibus_cyc = 0;
    sample();
    vectors++;
    if ({o_wb_cyc, o_ibus_ack} !== 2'b00) begin miscompares++; $display("FAIL ifetch_release: got %b want 00", {o_wb_cyc, o_ibus_ack}); end
    drive_pt();
  endtask

  task automatic test_dbus_write();
    drive_pt(); i_dbus_adr = 32'h2000; i_dbus_dat = 32'hCAFEBABE; i_dbus_sel = 4'h3; i_dbus_we = 1; i_dbus_cyc = 1;
    drive_pt(); sample();
    vectors++;
    if ({o_gnt, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_ibus_ack, o_dbus_ack} !== {2'b10, 32'h2000, 32'hCAFEBABE, 4'h3, 1'b1, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL dwrite_fields: got %b %h %h %h %b %b %b", o_gnt, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_ibus_ack, o_dbus_ack);
    end
    drive_pt(); i_wb_ack = 1; i_wb_rdt = 32'h5A5A5A5A;
    sample();
    vectors++;
    if ({o_dbus_ack, o_dbus_rdt, o_ibus_ack, o_ibus_rdt} !== {1'b1, 32'h5A5A5A5A, 1'b0, 32'h0}) begin
      miscompares++; $display("FAIL dwrite_ack: got %b %h %b %h", o_dbus_ack, o_dbus_rdt, o_ibus_ack, o_ibus_rdt);
    end
    drive_pt(); idle_inputs();
    drive_pt();
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    i_ibus_adr = 32'h40; i_dbus_adr = 32'h80; i_ibus_cyc = 1; i_dbus_cyc = 1;
    drive_pt(); sample();
    vectors++;
    if (o_gnt !== 2'b01) begin miscompares++; $display("FAIL sim_first_ibus: gnt got %b want 01", o_gnt); end
    drive_pt(); i_wb_ack = 1; i_wb_rdt = 32'h1;
    sample();
    vectors++;
    if ({o_ibus_ack, o_dbus_ack} !== 2'b10) begin miscompares++; $display("FAIL sim_ibus_ack: got %b want 10", {o_ibus_ack, o_dbus_ack}); end
    drive_pt(); i_wb_ack = 0; i_ibus_cyc = 0;
    sample();
    vectors++;
    if (o_wb_cyc !== 1'b0) begin miscompares++; $display("FAIL sim_gap: cyc got %b want 0", o_wb_cyc); end
    drive_pt(); sample();
    vectors++;
    if ({o_gnt, o_wb_adr} !== {2'b10, 32'h80}) begin miscompares++; $display("FAIL sim_then_dbus: got %b %h want 10 00000080", o_gnt, o_wb_adr); end
    drive_pt(); i_wb_ack = 1;
    sample();
    vectors++;
    if ({o_ibus_ack, o_dbus_ack} !== 2'b01) begin miscompares++; $display("FAIL sim_dbus_ack: got %b want 01", {o_ibus_ack, o_dbus_ack}); end
    drive_pt(); i_wb_ack = 0; i_dbus_cyc = 0;
    drive_pt(); i_ibus_cyc = 1; i_dbus_cyc = 1;
    drive_pt(); sample();
    vectors++;
    if (o_gnt !== 2'b01) begin miscompares++; $display("FAIL sim_alternate: gnt got %b want 01", o_gnt); end
    drive_pt(); i_wb_ack = 1;
    drive_pt(); i_wb_ack = 0; i_ibus_cyc = 0;
    drive_pt(); sample();
    vectors++;
    if (o_gnt !== 2'b10) begin miscompares++; $display("FAIL sim_alternate_d: gnt got %b want 10", o_gnt); end
    drive_pt(); i_wb_ack = 1;
    drive_pt(); idle_inputs();
    drive_pt();
  endtask

  task automatic test_watchdog();
    drive_pt(); i_dbus_adr = 32'h300; i_dbus_cyc = 1;
    for (int b = 1; b <= TO; b++) begin
      drive_pt(); sample();
      vectors++;
      if (b < TO && o_dbus_ack !== 1'b0) begin miscompares++; $display("FAIL wdt_early: cycle %0d ack got %b want 0", b, o_dbus_ack); end
      if (b == TO && {o_dbus_ack, o_dbus_rdt, o_timeout} !== {1'b1, 32'h0, 1'b0}) begin
        miscompares++; $display("FAIL wdt_expire: got ack %b rdt %h to %b want 1 0 0", o_dbus_ack, o_dbus_rdt, o_timeout);
      end
    end
    drive_pt(); i_dbus_cyc = 0;
    sample();
    vectors++;
    if ({o_timeout, o_wb_cyc} !== 2'b10) begin miscompares++; $display("FAIL wdt_flag_set: got %b want 10", {o_timeout, o_wb_cyc}); end
    drive_pt(); drive_pt(); sample();
    vectors++;
    if (o_timeout !== 1'b1) begin miscompares++; $display("FAIL wdt_sticky: got %b want 1", o_timeout); end
    drive_pt(); i_timeout_clr = 1;
    drive_pt(); i_timeout_clr = 0;
    sample();
    vectors++;
    if (o_timeout !== 1'b0) begin miscompares++; $display("FAIL wdt_clr: got %b want 0", o_timeout); end
    i_dbus_cyc = 1;
    for (int b = 1; b <= TO; b++) begin
      drive_pt();
      if (b == TO) begin i_wb_ack = 1; i_wb_rdt = 32'hABCD; end
    end
    sample();
    vectors++;
    if ({o_dbus_ack, o_dbus_rdt} !== {1'b1, 32'hABCD}) begin miscompares++; $display("FAIL wdt_real_ack: got %b %h want 1 0000abcd", o_dbus_ack, o_dbus_rdt); end
    drive_pt(); i_wb_ack = 0; i_dbus_cyc = 0;
    sample();
    vectors++;
    if (o_timeout !== 1'b0) begin miscompares++; $display("FAIL wdt_real_noflag: got %b want 0", o_timeout); end
    drive_pt();
  endtask

  task automatic test_reset_mid();
    drive_pt(); i_ibus_adr = 32'h500; i_ibus_cyc = 1;
    drive_pt(); sample();
    vectors++;
    if (o_wb_cyc !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy: cyc got %b want 1", o_wb_cyc); end
    #2 i_rst = 1; i_wb_ack = 1; i_wb_rdt = 32'h77;
    #1;
    vectors++;
    if ({o_wb_cyc, o_wb_stb, o_ibus_ack, o_dbus_ack} !== 4'b0) begin
      miscompares++; $display("FAIL rstmid_async: got %b want 0000", {o_wb_cyc, o_wb_stb, o_ibus_ack, o_dbus_ack});
    end
    drive_pt(); idle_inputs();
    drive_pt(); i_rst = 0; i_ibus_adr = 32'h504; i_ibus_cyc = 1;
    sample();
    vectors++;
    if (o_wb_cyc !== 1'b0) begin miscompares++; $display("FAIL rstmid_req: cyc got %b want 0", o_wb_cyc); end
    drive_pt(); sample();
    vectors++;
    if ({o_wb_cyc, o_gnt, o_wb_adr} !== {1'b1, 2'b01, 32'h504}) begin miscompares++; $display("FAIL rstmid_regrant: got %b %b %h", o_wb_cyc, o_gnt, o_wb_adr); end
    drive_pt(); i_wb_ack = 1;
    drive_pt(); idle_inputs();
    drive_pt();
  endtask

  task automatic test_abort_stray();
    drive_pt(); i_dbus_adr = 32'h600; i_dbus_cyc = 1;
    drive_pt(); sample();
    vectors++;
    if (o_gnt !== 2'b10) begin miscompares++; $display("FAIL abort_gnt: got %b want 10", o_gnt); end
    drive_pt(); i_dbus_cyc = 0;
    sample();
    vectors++;
    if (o_dbus_ack !== 1'b0) begin miscompares++; $display("FAIL abort_noack: got %b want 0", o_dbus_ack); end
    drive_pt(); sample();
    vectors++;
    if ({o_wb_cyc, o_gnt, o_dbus_ack} !== 4'b0) begin miscompares++; $display("FAIL abort_idle: got %b want 0000", {o_wb_cyc, o_gnt, o_dbus_ack}); end
    drive_pt(); i_wb_ack = 1; i_wb_rdt = 32'hDEAD;
    sample();
    vectors++;
    if ({o_ibus_ack, o_dbus_ack, o_ibus_rdt, o_dbus_rdt, o_wb_cyc} !== '0) begin
      miscompares++; $display("FAIL stray_ack: got %b %b %h %h %b want all 0", o_ibus_ack, o_dbus_ack, o_ibus_rdt, o_dbus_rdt, o_wb_cyc);
    end
    drive_pt(); i_wb_ack = 0;
    drive_pt();
  endtask

  task automatic test_random();
    int owner, age, last, recent, pick;
    bit to_flag, fire, forced, ocyc, ri, rd, ack_i_prev, ack_d_prev;
    logic [1:0]  e_gnt;
    logic [76:0] e_fld, a_fld;
    logic [65:0] e_ack, a_ack;
    logic [DW-1:0] e_rdt;
    owner = 0; age = 0; last = 2; recent = 0; to_flag = 0; ack_i_prev = 0; ack_d_prev = 0;
    pulse_reset();
    for (int n = 0; n < 2000; n++) begin
      drive_pt();
      if (ack_i_prev) i_ibus_cyc = 0;
      else if (i_ibus_cyc) begin if ($urandom_range(0, 39) == 0) i_ibus_cyc = 0; end
      else if ($urandom_range(0, 2) == 0) begin i_ibus_cyc = 1; i_ibus_adr = $urandom; end
      if (ack_d_prev) i_dbus_cyc = 0;
      else if (i_dbus_cyc) begin if ($urandom_range(0, 39) == 0) i_dbus_cyc = 0; end
      else if ($urandom_range(0, 2) == 0) begin
        i_dbus_cyc = 1; i_dbus_adr = $urandom; i_dbus_dat = $urandom;
        i_dbus_sel = 4'($urandom); i_dbus_we = 1'($urandom);
      end
      i_wb_ack = ($urandom_range(0, 3) == 0);
      i_wb_rdt = $urandom;
      i_timeout_clr = ($urandom_range(0, 15) == 0);
      sample();
      ocyc   = (owner == 1) ? i_ibus_cyc : i_dbus_cyc;
      forced = (owner != 0) && !i_wb_ack && ocyc && (age == TO - 1);
      fire   = (owner != 0) && (i_wb_ack || forced);
      e_rdt  = i_wb_ack ? i_wb_rdt : 32'h0;
      e_gnt  = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
      if (owner == 1)      e_fld = {i_ibus_adr, 32'h0, 4'hf, 1'b0, 1'b1, 1'b1, e_gnt, 1'b0, 1'b0};
      else if (owner == 2) e_fld = {i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, 1'b1, 1'b1, e_gnt, 1'b0, 1'b0};
      else                 e_fld = '0;
      e_fld[1:0] = '0;
      a_fld = {o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb, o_gnt, 2'b00};
      vectors++;
      if (a_fld !== e_fld) begin miscompares++; $display("FAIL rnd_bus cyc %0d: got %h want %h", n, a_fld, e_fld); end
      e_ack = {fire && owner == 1, fire && owner == 2, (fire && owner == 1) ? e_rdt : 32'h0, (fire && owner == 2) ? e_rdt : 32'h0};
      a_ack = {o_ibus_ack, o_dbus_ack, o_ibus_rdt, o_dbus_rdt};
      vectors++;
      if (a_ack !== e_ack) begin miscompares++; $display("FAIL rnd_ack cyc %0d: got %h want %h", n, a_ack, e_ack); end
      vectors++;
      if (o_timeout !== to_flag) begin miscompares++; $display("FAIL rnd_timeout cyc %0d: got %b want %b", n, o_timeout, to_flag); end
      ack_i_prev = fire && owner == 1;
      ack_d_prev = fire && owner == 2;
      if (forced) to_flag = 1; else if (i_timeout_clr) to_flag = 0;
      if (owner != 0) begin
        if (fire) begin recent = owner; owner = 0; end
        else begin recent = 0; if (!ocyc) owner = 0; else age++; end
      end else begin
        ri = i_ibus_cyc && recent != 1;
        rd = i_dbus_cyc && recent != 2;
        pick = (ri && rd) ? ((last == 1) ? 2 : 1) : ri ? 1 : rd ? 2 : 0;
        if (pick != 0) begin owner = pick; last = pick; age = 0; end
        recent = 0;
      end
    end
    drive_pt(); idle_inputs();
    drive_pt();
  endtask

  initial begin
    test_reset();
    test_ibus_fetch();
    test_dbus_write();
    test_simultaneous();
    test_watchdog();
    test_reset_mid();
    test_abort_stray();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
